maxpool_stream: RTL and testbench

//  Streaming 2x2 / stride-2 max-pool stage directly downstream of the pointwise conv stage.

---
 rtl/maxpool_stream_pkg.sv | 17 +
 rtl/maxpool_stream_max_lane.sv | 13 +
 rtl/maxpool_stream.sv | 128 ++++++++++++
 tb/tb_maxpool_stream.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_stream_pkg.sv
// Shared types and helpers for the streaming max-pool stage.
// Default lane width, FSM state encoding and a counter-width helper.
package maxpool_stream_pkg;

  localparam int N_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Index width for a range of size entries, never below one bit.
  function automatic int cnt_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/maxpool_stream_max_lane.sv
// max_lane: combinational signed maximum of two N-bit lanes.
// Ports: a, b in (N bits, two's complement); y out (larger of a, b).
module max_lane #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = ($signed(a) > $signed(b)) ? a : b;

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 / stride-2 max-pool, all channels in parallel.
// Ports: clk, rst_n (sync, active low), din_vld, din[CHANNEL*N] in;
//        dout[CHANNEL*N], dout_vld (pulse per window), dout_end (idle/frame done) out.
module maxpool_stream
  import maxpool_stream_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_vld,
  input  logic [CHANNEL*N-1:0] din,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_vld,
  output logic                 dout_end
);

  localparam int W   = CHANNEL * N;
  localparam int CW  = cnt_w(INPUT_SIZE);
  localparam int LBD = INPUT_SIZE / 2;
  localparam int LW  = cnt_w(LBD);

  if ((INPUT_SIZE % 2) != 0 || INPUT_SIZE < 2) begin : g_bad_size
    $error("maxpool_stream: INPUT_SIZE must be even and >= 2");
  end

  state_t        state;
  state_t        state_d;
  logic          end_d;

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          last_px;
  logic          pair_top;
  logic          win_done;

  logic [W-1:0]  hold;
  logic [W-1:0]  linebuf [LBD];
  logic [LW-1:0] lb_idx;
  logic [W-1:0]  lb_rd;
  logic [W-1:0]  max2;
  logic [W-1:0]  max3;

  assign col_last = (col == CW'(INPUT_SIZE - 1));
  assign row_last = (row == CW'(INPUT_SIZE - 1));
  assign last_px  = din_vld & col_last & row_last;
  // Odd column closes a horizontal pair; the row parity says
  // whether it goes to the line buffer or finishes a window.
  assign pair_top = din_vld & col[0] & ~row[0];
  assign win_done = din_vld & col[0] & row[0];

  assign lb_idx = LW'(col >> 1);
  assign lb_rd  = linebuf[lb_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (din_vld) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (din_vld) state_d = ACTIVE;
      ACTIVE:  if (last_px) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pixel arriving while idle (including the cycle of the final
  // pulse) restarts the frame, so dout_end drops on that same edge.
  always_comb begin
    end_d = dout_end;
    case (state)
      IDLE:    if (din_vld) end_d = 1'b0;
      ACTIVE:  if (last_px) end_d = 1'b1;
      default: end_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (din_vld && !col[0]) hold <= din;
    if (pair_top) linebuf[lb_idx] <= max2;
  end

  for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
    max_lane #(.N(N)) u_max2 (
      .a (hold[i*N +: N]),
      .b (din[i*N +: N]),
      .y (max2[i*N +: N])
    );
    max_lane #(.N(N)) u_max3 (
      .a (max2[i*N +: N]),
      .b (lb_rd[i*N +: N]),
      .y (max3[i*N +: N])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_end <= 1'b1;
    end else begin
      dout_vld <= win_done;
      dout_end <= end_d;
      if (win_done) dout <= max3;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: N=16, CHANNEL=2, INPUT_SIZE=4.
// Checks reset, ramp, signed values, gaps, mid-frame reset, chaining, lanes.
module tb_maxpool_stream;

  localparam int N  = 16;
  localparam int C  = 2;
  localparam int IS = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           din_vld = 1'b0;
  logic [C*N-1:0] din = '0;
  logic [C*N-1:0] dout;
  logic           dout_vld;
  logic           dout_end;

  int nvec = 0;
  int nerr = 0;
  int pcnt = 0;

  logic [15:0] q_l0[$];
  logic [15:0] q_l1[$];
  int          q_cyc[$];
  logic        q_end[$];
  int          pix_cyc[$];

  maxpool_stream #(.N(N), .CHANNEL(C), .INPUT_SIZE(IS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_end (dout_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      q_l0.push_back(dout[15:0]);
      q_l1.push_back(dout[31:16]);
      q_cyc.push_back(pcnt);
      q_end.push_back(dout_end);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    din = {b, a};
    din_vld = 1'b1;
    pix_cyc.push_back(pcnt);
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q;
    q_l0.delete();
    q_l1.delete();
    q_cyc.delete();
    q_end.delete();
    pix_cyc.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    nvec++;
    if (dout_vld !== 1'b0 || dout !== '0 || dout_end !== 1'b1) begin
      nerr++;
      $display("FAIL reset got vld=%b dout=%h end=%b want 0 00000000 1",
               dout_vld, dout, dout_end);
    end
    idle(2);
    nvec++;
    if (q_l0.size() != 0) begin
      nerr++;
      $display("FAIL reset_quiet got %0d pulses want 0", q_l0.size());
    end
  endtask

  task automatic test_ramp;
    int ev[4] = '{5, 7, 13, 15};
    clear_q();
    for (int k = 0; k < 16; k++) send(16'(k), 16'(k));
    idle(3);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL ramp_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'(ev[j]) || q_l1[j] !== 16'(ev[j])) begin
        nerr++;
        $display("FAIL ramp_val[%0d] got %0d/%0d want %0d",
                 j, q_l0[j], q_l1[j], ev[j]);
      end
      nvec++;
      if (q_cyc[j] != pix_cyc[ev[j]] + 1) begin
        nerr++;
        $display("FAIL ramp_lat[%0d] got cyc %0d want %0d",
                 j, q_cyc[j], pix_cyc[ev[j]] + 1);
      end
      nvec++;
      if (q_end[j] !== (j == 3)) begin
        nerr++;
        $display("FAIL ramp_end[%0d] got %b want %b", j, q_end[j], j == 3);
      end
    end
    nvec++;
    if (dout !== {16'd15, 16'd15} || dout_end !== 1'b1) begin
      nerr++;
      $display("FAIL ramp_hold got %h end=%b want 000f000f 1", dout, dout_end);
    end
  endtask

  task automatic test_negatives;
    clear_q();
    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = (k == 0 || k == 3 || k == 12 || k == 15) ? 16'hFFFF : 16'hFFFD;
      b = (k == 1 || k == 6 || k == 9 || k == 14) ? 16'hFFFF : 16'hFFFD;
      send(a, b);
    end
    idle(3);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL neg_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'hFFFF || q_l1[j] !== 16'hFFFF) begin
        nerr++;
        $display("FAIL neg_val[%0d] got %h/%h want ffff", j, q_l0[j], q_l1[j]);
      end
    end
  endtask

  task automatic test_signed_mix;
    clear_q();
    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = (k == 4 || k == 2 || k == 13 || k == 11) ? 16'd1 : 16'hFFFB;
      b = (k == 5 || k == 7 || k == 8 || k == 10) ? 16'd3 : 16'h8000;
      send(a, b);
    end
    idle(3);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL mix_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'd1 || q_l1[j] !== 16'd3) begin
        nerr++;
        $display("FAIL mix_val[%0d] got %h/%h want 0001/0003",
                 j, q_l0[j], q_l1[j]);
      end
    end
  endtask

  task automatic test_gaps;
    int ev[4] = '{5, 7, 13, 15};
    clear_q();
    for (int k = 0; k < 16; k++) begin
      send(16'(k), 16'(k));
      idle(2 + int'($urandom_range(2)));
    end
    idle(2);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL gap_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'(ev[j]) || q_l1[j] !== 16'(ev[j])) begin
        nerr++;
        $display("FAIL gap_val[%0d] got %0d/%0d want %0d",
                 j, q_l0[j], q_l1[j], ev[j]);
      end
      nvec++;
      if (q_cyc[j] != pix_cyc[ev[j]] + 1) begin
        nerr++;
        $display("FAIL gap_lat[%0d] got cyc %0d want %0d",
                 j, q_cyc[j], pix_cyc[ev[j]] + 1);
      end
    end
  endtask

  task automatic test_midframe_reset;
    int ev[4] = '{5, 7, 13, 15};
    for (int k = 0; k < 6; k++) send(16'(1000 + k), 16'(1000 + k));
    idle(2);
    clear_q();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    nvec++;
    if (dout_vld !== 1'b0 || dout !== '0 || dout_end !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid got vld=%b dout=%h end=%b want 0 00000000 1",
               dout_vld, dout, dout_end);
    end
    idle(2);
    nvec++;
    if (q_l0.size() != 0) begin
      nerr++;
      $display("FAIL rst_quiet got %0d pulses want 0", q_l0.size());
    end
    for (int k = 0; k < 16; k++) send(16'(k), 16'(k));
    idle(3);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL rst_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'(ev[j]) || q_l1[j] !== 16'(ev[j])) begin
        nerr++;
        $display("FAIL rst_val[%0d] got %0d/%0d want %0d",
                 j, q_l0[j], q_l1[j], ev[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ev[8] = '{5, 7, 13, 15, 105, 107, 113, 115};
    int dp[8] = '{5, 7, 13, 15, 21, 23, 29, 31};
    int bad = 0;
    clear_q();
    for (int k = 0; k < 32; k++) begin
      int v;
      v = (k < 16) ? k : 100 + (k - 16);
      if (k == 16) begin
        nvec++;
        if (dout_vld !== 1'b1) begin
          nerr++;
          $display("FAIL b2b_align got vld=%b want 1", dout_vld);
        end
      end
      if (k >= 17 && dout_end !== 1'b0) bad++;
      send(16'(v), 16'(v));
    end
    idle(3);
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL b2b_end got %0d high cycles want 0", bad);
    end
    nvec++;
    if (q_l0.size() != 8) begin
      nerr++;
      $display("FAIL b2b_count got %0d want 8", q_l0.size());
    end
    for (int j = 0; j < 8 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'(ev[j]) || q_l1[j] !== 16'(ev[j])) begin
        nerr++;
        $display("FAIL b2b_val[%0d] got %0d/%0d want %0d",
                 j, q_l0[j], q_l1[j], ev[j]);
      end
      nvec++;
      if (q_cyc[j] != pix_cyc[dp[j]] + 1) begin
        nerr++;
        $display("FAIL b2b_lat[%0d] got cyc %0d want %0d",
                 j, q_cyc[j], pix_cyc[dp[j]] + 1);
      end
    end
    nvec++;
    if (dout_end !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_done got end=%b want 1", dout_end);
    end
  endtask

  task automatic test_lanes;
    int e0[4] = '{100, 0, 0, 0};
    int e1[4] = '{0, 0, 0, 100};
    clear_q();
    for (int k = 0; k < 16; k++) begin
      send((k == 0) ? 16'd100 : 16'd0, (k == 15) ? 16'd100 : 16'd0);
    end
    idle(3);
    nvec++;
    if (q_l0.size() != 4) begin
      nerr++;
      $display("FAIL lane_count got %0d want 4", q_l0.size());
    end
    for (int j = 0; j < 4 && j < q_l0.size(); j++) begin
      nvec++;
      if (q_l0[j] !== 16'(e0[j]) || q_l1[j] !== 16'(e1[j])) begin
        nerr++;
        $display("FAIL lane_val[%0d] got %0d/%0d want %0d/%0d",
                 j, q_l0[j], q_l1[j], e0[j], e1[j]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ramp();
    test_negatives();
    test_signed_mix();
    test_gaps();
    test_midframe_reset();
    test_back_to_back();
    test_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
